// File: rtl/mem_skew_feeder.sv
// Read sequencer for the 4x4 operand memory: issues the diagonal (wavefront)
// read pattern the systolic array needs, waits for the array to drain, then pulses done.
module mem_skew_feeder #(
    parameter int unsigned DRAIN = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic       feed_valid,
    output logic [3:0] read_enable,
    output logic [7:0] read_elem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] T_LAST     = 3'd6;
    localparam bit         NO_DRAIN   = (DRAIN == 0);
    localparam logic [3:0] DRAIN_LOAD = NO_DRAIN ? 4'd0 : 4'(DRAIN - 1);

    state_t     state_q, state_d;
    logic [2:0] t_q, t_d;
    logic [3:0] dcnt_q, dcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            t_q     <= 3'd0;
            dcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Stall simply leaves the defaults (hold) in place for FEED and DRAIN.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FEED;
                    t_d     = 3'd0;
                end
            end
            S_FEED: begin
                if (!stall) begin
                    if (t_q == T_LAST) begin
                        t_d = 3'd0;
                        if (NO_DRAIN) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DRAIN;
                            dcnt_d  = DRAIN_LOAD;
                        end
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    if (dcnt_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        dcnt_d = dcnt_q - 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Column l reads row (t - l) during the four steps l..l+3 of the wavefront.
    logic [2:0] diff;
    always_comb begin
        read_enable = 4'b0000;
        read_elem   = 8'h00;
        diff        = 3'd0;
        if (state_q == S_FEED) begin
            for (int l = 0; l < 4; l++) begin
                diff = t_q - 3'(l);
                if ((t_q >= 3'(l)) && (diff <= 3'd3)) begin
                    read_enable[l]     = 1'b1;
                    read_elem[2*l +: 2] = diff[1:0];
                end
            end
        end
    end

    assign feed_valid = |read_enable;
    assign busy       = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_skew_feeder.sv
// Directed bench for mem_skew_feeder: a DRAIN=7 instance for most scenarios and
// a DRAIN=0 instance for the no-drain timing.
module tb_mem_skew_feeder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic       feed_valid;
    logic [3:0] read_enable;
    logic [7:0] read_elem;

    logic       start0;
    logic       stall0;
    logic       busy0;
    logic       done0;
    logic       feed_valid0;
    logic [3:0] read_enable0;
    logic [7:0] read_elem0;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  re_tab [7];
    logic [7:0]  el_tab [7];
    logic [11:0] exp_q [$];

    mem_skew_feeder #(.DRAIN(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .feed_valid  (feed_valid),
        .read_enable (read_enable),
        .read_elem   (read_elem)
    );

    mem_skew_feeder #(.DRAIN(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start0),
        .stall       (stall0),
        .busy        (busy0),
        .done        (done0),
        .feed_valid  (feed_valid0),
        .read_enable (read_enable0),
        .read_elem   (read_elem0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b1;
        start0 = 1'b1;
        stall  = 1'b0;
        stall0 = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, done, feed_valid, read_enable, read_elem} !== 15'd0) begin
            failures++;
            $display("FAIL reset_hold: outputs=%h expected=0", {busy, done, feed_valid, read_enable, read_elem});
        end
        start  = 1'b0;
        start0 = 1'b0;
        rst_n  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if ({busy, done, feed_valid, read_enable, read_elem} !== 15'd0) begin
                failures++;
                $display("FAIL reset_release k=%0d: outputs=%h expected=0", k, {busy, done, feed_valid, read_enable, read_elem});
            end
        end
    endtask

    task automatic test_nominal();
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back({re_tab[i], el_tab[i]});
        start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            start = 1'b0;
            if (k <= 7) begin
                logic [11:0] exp;
                exp = exp_q.pop_front();
                checks++;
                if ({read_enable, read_elem} !== exp || busy !== 1'b1 || feed_valid !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL nominal_feed k=%0d: re=%b el=%h busy=%b fv=%b done=%b expected re=%b el=%h busy=1 fv=1 done=0",
                             k, read_enable, read_elem, busy, feed_valid, done, exp[11:8], exp[7:0]);
                end
            end else if (k <= 14) begin
                checks++;
                if (busy !== 1'b1 || read_enable !== 4'd0 || read_elem !== 8'd0 || feed_valid !== 1'b0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL nominal_drain k=%0d: busy=%b re=%b el=%h fv=%b done=%b expected busy=1 others 0",
                             k, busy, read_enable, read_elem, feed_valid, done);
                end
            end else if (k == 15) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || read_enable !== 4'd0) begin
                    failures++;
                    $display("FAIL nominal_done: done=%b busy=%b re=%b expected done=1 busy=0 re=0", done, busy, read_enable);
                end
            end else begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL nominal_idle: done=%b busy=%b expected 0 0", done, busy);
                end
            end
        end
    endtask

    task automatic test_stall();
        int idx;
        start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            start = 1'b0;
            if (k <= 4)       idx = k - 1;
            else if (k <= 7)  idx = 3;
            else              idx = k - 4;
            if (k <= 10) begin
                checks++;
                if (read_enable !== re_tab[idx] || read_elem !== el_tab[idx] || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_feed k=%0d: re=%b el=%h busy=%b expected re=%b el=%h busy=1",
                             k, read_enable, read_elem, busy, re_tab[idx], el_tab[idx]);
                end
            end else if (k <= 17) begin
                checks++;
                if (busy !== 1'b1 || read_enable !== 4'd0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_drain k=%0d: busy=%b re=%b done=%b expected 1 0 0", k, busy, read_enable, done);
                end
            end else if (k == 18) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_done: done=%b busy=%b expected 1 0", done, busy);
                end
            end else begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_done_no_stretch: done=%b busy=%b expected 0 0", done, busy);
                end
            end
            // stall across three edges while t=3; also stall during DONE
            if (k == 4)  stall = 1'b1;
            if (k == 7)  stall = 1'b0;
            if (k == 18) stall = 1'b1;
        end
        stall = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            start = 1'b0;
            if (done === 1'b1) dones++;
            if (k <= 7) begin
                checks++;
                if (read_enable !== re_tab[k-1] || read_elem !== el_tab[k-1]) begin
                    failures++;
                    $display("FAIL busy_start_feed k=%0d: re=%b el=%h expected re=%b el=%h",
                             k, read_enable, read_elem, re_tab[k-1], el_tab[k-1]);
                end
            end else if (k == 15) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_start_done: done=%b expected 1", done);
                end
            end else if (k >= 16) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || read_enable !== 4'd0) begin
                    failures++;
                    $display("FAIL busy_start_idle k=%0d: busy=%b done=%b re=%b expected 0 0 0", k, busy, done, read_enable);
                end
            end
            if (k == 3 || k == 15) start = 1'b1;
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL busy_start_done_count: got=%0d expected=1", dones);
        end
    endtask

    task automatic test_drain_zero();
        start0 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            start0 = 1'b0;
            if (k <= 7) begin
                checks++;
                if (read_enable0 !== re_tab[k-1] || read_elem0 !== el_tab[k-1] || busy0 !== 1'b1) begin
                    failures++;
                    $display("FAIL drain0_feed k=%0d: re=%b el=%h busy=%b expected re=%b el=%h busy=1",
                             k, read_enable0, read_elem0, busy0, re_tab[k-1], el_tab[k-1]);
                end
            end else if (k == 8) begin
                checks++;
                if (done0 !== 1'b1 || busy0 !== 1'b0 || read_enable0 !== 4'd0) begin
                    failures++;
                    $display("FAIL drain0_done: done=%b busy=%b re=%b expected 1 0 0", done0, busy0, read_enable0);
                end
            end else begin
                checks++;
                if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                    failures++;
                    $display("FAIL drain0_idle: done=%b busy=%b expected 0 0", done0, busy0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            start = 1'b0;
        end
        checks++;
        if (read_enable !== 4'b1110) begin
            failures++;
            $display("FAIL reset_mid_pre: re=%b expected 1110", read_enable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, feed_valid, read_enable, read_elem} !== 15'd0) begin
            failures++;
            $display("FAIL reset_mid_async: outputs=%h expected=0", {busy, done, feed_valid, read_enable, read_elem});
        end
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_mid_no_resume: active_cycles=%0d expected=0", dones);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (read_enable !== 4'b0001 || read_elem !== 8'h00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_restart: re=%b el=%h busy=%b expected 0001 00 1", read_enable, read_elem, busy);
        end
    endtask

    initial begin
        re_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        el_tab = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C, 8'hB0, 8'hC0};
        test_reset();
        test_nominal();
        test_stall();
        test_back_to_back();
        test_drain_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
